// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//
// Shares the single data-RAM port between the CPU load/store path and the
// UART program uploader. Each access goes through a small registered FSM
// (IDLE -> WR, or IDLE -> RD -> RDATA). Simultaneous requests are resolved
// round-robin. While upg_lock is high the CPU receives no new grants. A
// saturating counter records how many cycles the CPU has spent stalled.
//
// Ports
//   clk, rst                  clock; asynchronous active-low reset
//   cpu_req/we/addr/wdata     CPU request; fields held stable until cpu_ack
//   cpu_ack, cpu_rdata        one-cycle completion pulse; load data
//   cpu_stall                 combinational: request pending, not yet acked
//   upg_req/addr/wdata        uploader write request
//   upg_ack                   one-cycle completion pulse
//   upg_lock                  upload session active; blocks new CPU grants
//   ram_en/wen/addr/wdata     RAM request side
//   ram_rdata                 RAM read data, one cycle after a read enable
//   owner                     00 none, 01 CPU, 10 uploader
//   wait_cnt                  saturating count of cpu_stall cycles

module dmem_port_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              upg_req,
  input  logic [ADDR_W-1:0] upg_addr,
  input  logic [DATA_W-1:0] upg_wdata,
  output logic              upg_ack,
  input  logic              upg_lock,
  output logic              ram_en,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [1:0]        owner,
  output logic [15:0]       wait_cnt
);

  typedef enum logic [1:0] {IDLE, WR, RD, RDATA} state_t;

  state_t            state;
  state_t            state_next;
  logic [1:0]        rst_sync;
  logic              run_ok;
  logic              cpu_elig;
  logic              upg_elig;
  logic              grant_any;
  logic              grant_upg;
  logic              last_upg;
  logic              lat_upg;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] rdata_hold;

  // Reset assertion takes effect immediately, but release is delayed through
  // two flops. Grants are held off until the release has propagated, so the
  // FSM never leaves IDLE on the edges that immediately follow reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync <= 2'b00;
    else      rst_sync <= {rst_sync[0], 1'b1};
  end

  assign run_ok   = rst_sync[1];
  assign cpu_elig = run_ok & cpu_req & ~upg_lock;
  assign upg_elig = run_ok & upg_req;
  assign grant_any = (state == IDLE) & (cpu_elig | upg_elig);

  // The uploader wins if it is the only requester, or on a tie when the CPU
  // held the previous grant. last_upg resets to 1 so the CPU wins the first
  // tie after reset.
  assign grant_upg = upg_elig & (~cpu_elig | ~last_upg);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic. Uploader requests are always writes.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_any) state_next = (grant_upg | cpu_we) ? WR : RD;
      WR:      state_next = IDLE;
      RD:      state_next = RDATA;
      RDATA:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Capture the winner's request at the grant edge. The requester may change
  // or drop its fields afterwards without disturbing the access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_upg  <= 1'b1;
      lat_upg   <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (grant_any) begin
      last_upg  <= grant_upg;
      lat_upg   <= grant_upg;
      lat_addr  <= grant_upg ? upg_addr  : cpu_addr;
      lat_wdata <= grant_upg ? upg_wdata : cpu_wdata;
    end
  end

  // Keep the last load result on cpu_rdata until the next CPU load completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 rdata_hold <= '0;
    else if (state == RDATA)  rdata_hold <= ram_rdata;
  end

  // Count CPU stall cycles. The counter sticks at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                               wait_cnt <= 16'h0000;
    else if (cpu_stall && wait_cnt != 16'hFFFF) wait_cnt <= wait_cnt + 16'h0001;
  end

  // Outputs are decoded from the current state, so an asynchronous reset
  // forces every output to zero in the same instant. During RDATA, load data
  // passes straight through so that it is valid in the same cycle as cpu_ack.
  always_comb begin
    ram_en    = 1'b0;
    ram_wen   = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    cpu_ack   = 1'b0;
    upg_ack   = 1'b0;
    owner     = 2'b00;
    cpu_rdata = rdata_hold;
    case (state)
      WR: begin
        ram_en    = 1'b1;
        ram_wen   = 1'b1;
        ram_addr  = lat_addr;
        ram_wdata = lat_wdata;
        cpu_ack   = ~lat_upg;
        upg_ack   = lat_upg;
        owner     = lat_upg ? 2'b10 : 2'b01;
      end
      RD: begin
        ram_en   = 1'b1;
        ram_addr = lat_addr;
        owner    = lat_upg ? 2'b10 : 2'b01;
      end
      RDATA: begin
        cpu_ack   = 1'b1;
        cpu_rdata = ram_rdata;
        owner     = lat_upg ? 2'b10 : 2'b01;
      end
      default: ;
    endcase
  end

  // The stall signal is combinational so the CPU can freeze its pipeline in
  // the same cycle.
  assign cpu_stall = cpu_req & ~cpu_ack;

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Arbiter and sequencer for the single data-memory port shared by the CPU load/store path and the UART program uploader. It sits between both requesters and the data RAM. It serialises their accesses with a registered FSM, enforces round-robin fairness, and locks out the CPU for the length of an upload session. It also keeps a saturating count of CPU wait cycles for debug.

## Interface
Parameters:
- ADDR_W, 14, word-address width of the data RAM
- DATA_W, 32, data word width

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request; held with fields stable until cpu_ack
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  store data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  load data; valid with cpu_ack, held until the next CPU load ack
- cpu_stall  out  1  high while cpu_req is pending and not yet acked
- upg_req  in  1  uploader write request; held until upg_ack
- upg_addr  in  ADDR_W  uploader word address
- upg_wdata  in  DATA_W  uploader data
- upg_ack  out  1  one-cycle completion pulse
- upg_lock  in  1  upload session active; the CPU is never granted while high
- ram_en  out  1  RAM access enable
- ram_wen  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM word address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid exactly 1 cycle after ram_en with ram_wen = 0
- owner  out  2  current grant: 00 none, 01 CPU, 10 uploader
- wait_cnt  out  16  saturating count of cpu_stall cycles

## Operation
- FSM states: IDLE, WR, RD, RDATA.
- IDLE transitions:
  - Compute the eligible set: CPU is eligible if cpu_req & !upg_lock; uploader is eligible if upg_req.
  - Neither eligible: stay in IDLE.
  - One eligible: grant it.
  - Both eligible: grant the requester other than last_grant.
  - Update last_grant on every grant.
  - Latch the grantee's address, data and direction into internal registers.
  - Go to WR if the latched op is a write (uploader requests are always writes), else go to RD.
- WR state: ram_en = 1, ram_wen = 1, ram_addr/ram_wdata come from the latches. Ack the owner in this cycle, then go to IDLE.
- RD state: ram_en = 1, ram_wen = 0, ram_addr comes from the latch. Go to RDATA.
- RDATA state: capture ram_rdata into cpu_rdata, assert cpu_ack, go to IDLE.
- owner = 00 in IDLE; otherwise it shows the latched grantee.
- RAM outputs are all 0 in IDLE and RDATA. ram_wen is never 1 without ram_en.
- cpu_stall = cpu_req & !cpu_ack. It is combinational so the CPU freezes PC/pipeline in the same cycle.
- wait_cnt increments by 1 on every cycle with cpu_stall = 1 and saturates at 16'hFFFF. It does not wrap.
- A transaction in progress always completes, even if:
  - upg_lock rises in the middle of it, or
  - the requester drops req (the ack still pulses and the requester ignores it).
- upg_lock only blocks new CPU grants.

## Timing
- Reset (rst = 0, async): state = IDLE, last_grant = uploader (so the CPU wins the first tie). All outputs are 0: cpu_ack, cpu_rdata, upg_ack, ram_en, ram_wen, ram_addr, ram_wdata, owner, wait_cnt. cpu_stall follows cpu_req (combinational).
- Reset deassertion is synchronised internally to clk (2-flop). The FSM leaves IDLE no earlier than the 2nd rising edge after rst rises.
- Write latency: req seen high in IDLE at edge N, then WR during cycle N+1 with ack high in that cycle. Earliest next grant is at edge N+2.
- Read latency: req at edge N, RD in cycle N+1, RDATA/cpu_ack with data in cycle N+2. Earliest next grant is at edge N+3.
- Throughput: 1 write per 2 cycles, 1 read per 3 cycles.
- Acks are exactly 1 cycle wide. cpu_ack and upg_ack are never high together.
- A requester that keeps req high after its ack is treated as a new request at the next IDLE.
- Reset asserted mid-transaction aborts it immediately: no ack, RAM outputs 0.

## Test plan
- CPU store then load to the same address: cpu_we = 1, cpu_addr = 0x0010, cpu_wdata = 0xDEADBEEF. Required:
  - ram_wen pulses 1 cycle and cpu_ack comes 1 cycle after req.
  - The following load gets cpu_ack 2 cycles after its grant edge with cpu_rdata = 0xDEADBEEF.
  - wait_cnt = 3.
- Simultaneous requests from reset: the CPU is granted first (owner = 01). With both kept high, grants alternate 01, 10, 01, 10 across four transactions.
- upg_lock = 1 with cpu_req and upg_req both high for 20 cycles:
  - Only upg_ack pulses (10 writes).
  - cpu_stall stays high throughout and wait_cnt = 20.
  - After lock drops, the CPU is granted at the next IDLE.
- upg_lock rises during RD of a CPU load of address 0x0004 containing 0x12345678: RDATA still completes with cpu_rdata = 0x12345678. After that only the uploader is granted.
- wait_cnt saturation: hold cpu_req with upg_lock = 1 for 70000 cycles. wait_cnt stays at 16'hFFFF and does not wrap.
- Reset asserted during WR: all outputs go to 0 asynchronously with no ack. After release and 2 edges, a pending request is granted normally.
